// File: rtl/bankp_rom_pkg.sv
// rtl/bankp_rom_pkg.sv - BankPanic ROM region map and download sequencer types
package bankp_rom_pkg;

    localparam int REGION_CNT = 4;

    typedef enum logic [1:0] {RG_CPU, RG_FG, RG_BG, RG_PROM} region_e;

    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI} state_e;

    function automatic logic [26:0] region_base(input int idx);
        case (idx)
            0:       return 27'h00000;
            1:       return 27'h0E000;
            2:       return 27'h10000;
            default: return 27'h18000;
        endcase
    endfunction

    function automatic logic [26:0] region_size(input int idx);
        case (idx)
            0:       return 27'h0E000;
            1:       return 27'h02000;
            2:       return 27'h08000;
            default: return 27'h00220;
        endcase
    endfunction

endpackage

// File: rtl/rom_dl_sequencer_if.sv
// rtl/rom_dl_sequencer_if.sv - hps_io download side and core ROM write side of the sequencer
interface rom_dl_sequencer_if #(parameter int ROM_AW = 16) ();
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [26:0]       ioctl_addr;
    logic [15:0]       ioctl_dout;
    logic              ioctl_wait;
    logic              rom_we;
    logic [1:0]        rom_sel;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              core_reset;
    logic              dl_done;
    logic              dl_err;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait, rom_we, rom_sel, rom_addr, rom_data, core_reset, dl_done, dl_err
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait, rom_we, rom_sel, rom_addr, rom_data, core_reset, dl_done, dl_err
    );
endinterface

// File: rtl/rom_region_decode.sv
// rtl/rom_region_decode.sv - byte address to ROM region select and region-relative address
module rom_region_decode
    import bankp_rom_pkg::*;
#(
    parameter int ROM_AW = 16
) (
    input  logic [26:0]       byte_addr,
    output logic [1:0]        sel,
    output logic [ROM_AW-1:0] rel_addr,
    output logic              hit
);

    always_comb begin
        hit      = 1'b0;
        sel      = 2'd0;
        rel_addr = '0;
        for (int i = 0; i < REGION_CNT; i++) begin
            if (!hit && byte_addr >= region_base(i) &&
                byte_addr < region_base(i) + region_size(i)) begin
                hit      = 1'b1;
                sel      = 2'(i);
                rel_addr = ROM_AW'(byte_addr - region_base(i));
            end
        end
    end

endmodule

// File: rtl/rom_dl_sequencer.sv
// rtl/rom_dl_sequencer.sv - splits ioctl words into ROM byte writes and sequences core reset
module rom_dl_sequencer
    import bankp_rom_pkg::*;
#(
    parameter int RST_HOLD = 16,
    parameter int ROM_AW   = 16
) (
    input logic               clk_sys,
    input logic               reset_n,
    rom_dl_sequencer_if.slave bus
);

    localparam int HW = $clog2(RST_HOLD + 1);

    state_e            state;
    logic [26:0]       lat_addr;
    logic [15:0]       lat_data;
    logic [HW-1:0]     hold_cnt;
    logic              dl_active;
    logic              dl_active_q;
    logic              wrote_any;
    logic              wr_accept;
    logic [26:0]       dec_addr;
    logic [7:0]        dec_byte;
    logic [1:0]        dec_sel;
    logic [ROM_AW-1:0] dec_rel;
    logic              dec_hit;
    logic              rom_we_q;
    logic [1:0]        rom_sel_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic [7:0]        rom_data_q;
    logic              ioctl_wait_q;
    logic              dl_done_q;
    logic              dl_err_q;

    assign dl_active = bus.ioctl_download && (bus.ioctl_index == 8'd0);
    assign wr_accept = bus.ioctl_wr && dl_active && (state == ST_IDLE);

    // Low byte is decoded straight from hps_io so the first write lands one cycle after the strobe
    assign dec_addr = (state == ST_IDLE) ? bus.ioctl_addr      : lat_addr + 27'd1;
    assign dec_byte = (state == ST_IDLE) ? bus.ioctl_dout[7:0] : lat_data[15:8];

    rom_region_decode #(.ROM_AW(ROM_AW)) u_decode (
        .byte_addr (dec_addr),
        .sel       (dec_sel),
        .rel_addr  (dec_rel),
        .hit       (dec_hit)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            lat_addr     <= '0;
            lat_data     <= '0;
            hold_cnt     <= HW'(RST_HOLD);
            dl_active_q  <= 1'b0;
            wrote_any    <= 1'b0;
            rom_we_q     <= 1'b0;
            rom_sel_q    <= '0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            ioctl_wait_q <= 1'b0;
            dl_done_q    <= 1'b0;
            dl_err_q     <= 1'b0;
        end else begin
            rom_we_q    <= 1'b0;
            dl_active_q <= dl_active;

            if (dl_active && !dl_active_q) begin
                dl_done_q <= 1'b0;
                dl_err_q  <= 1'b0;
                wrote_any <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (wr_accept) begin
                        lat_addr     <= bus.ioctl_addr;
                        lat_data     <= bus.ioctl_dout;
                        state        <= ST_LO;
                        ioctl_wait_q <= 1'b1;
                    end
                end
                ST_LO: state <= ST_HI;
                default: begin
                    state        <= ST_IDLE;
                    ioctl_wait_q <= 1'b0;
                end
            endcase

            // A byte outside every region is dropped and flagged instead of written
            if (wr_accept || state == ST_LO) begin
                rom_we_q   <= dec_hit;
                rom_sel_q  <= dec_sel;
                rom_addr_q <= dec_rel;
                rom_data_q <= dec_byte;
                if (dec_hit) wrote_any <= 1'b1;
                else         dl_err_q  <= 1'b1;
            end

            if (dl_active || state != ST_IDLE) begin
                hold_cnt <= HW'(RST_HOLD);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
                if (hold_cnt == HW'(1) && wrote_any && !dl_err_q) dl_done_q <= 1'b1;
            end
        end
    end

    assign bus.ioctl_wait = ioctl_wait_q;
    assign bus.rom_we     = rom_we_q;
    assign bus.rom_sel    = rom_sel_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.rom_data   = rom_data_q;
    assign bus.dl_done    = dl_done_q;
    assign bus.dl_err     = dl_err_q;
    assign bus.core_reset = !reset_n || dl_active || (state != ST_IDLE) || (hold_cnt != '0);

endmodule
